// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port bypass picker for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;
    localparam int MAX_NW   = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    // Result of the bypass pick: whether any write port matched, and which one.
    typedef struct packed {
        logic hit;
        logic port;
    } byp_t;

    // Highest-indexed matching write port wins, same as the commit order.
    function automatic byp_t bypass_sel(input logic [MAX_NW-1:0] hit);
        byp_t s;
        s.hit  = |hit;
        s.port = hit[1];
        return s;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write ports, issue notification and debug tap.
// Latency: reads combinational, writes/issue captured on the rising clk edge.
// Backpressure: none; every port is accepted every cycle.
//   rd_addr/rd_data/rd_busy : NR packed read ports
//   wr_en/wr_addr/wr_data   : NW packed write ports
//   iss_en/iss_addr         : destination of a newly issued producer
//   dbg_data                : live copy of the debug register
interface regfile_mp_if #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter int NR      = 2,
    parameter int NW      = 1
);
    logic [NR*A_WIDTH-1:0] rd_addr;
    logic [NR*D_WIDTH-1:0] rd_data;
    logic [NR-1:0]         rd_busy;
    logic [NW-1:0]         wr_en;
    logic [NW*A_WIDTH-1:0] wr_addr;
    logic [NW*D_WIDTH-1:0] wr_data;
    logic                  iss_en;
    logic [A_WIDTH-1:0]    iss_addr;
    logic [D_WIDTH-1:0]    dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, dbg_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write-back.
// Latency: busy bits update on the rising clk edge; async active-low clear.
// Backpressure: none.
//   iss_en/iss_addr : set request;  wr_en/wr_addr : clear requests;  busy : bit per register
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int A_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_en,
    input  logic [A_WIDTH-1:0]       iss_addr,
    input  logic [MAX_NW-1:0]        wr_en,
    input  logic [MAX_NW*A_WIDTH-1:0] wr_addr,
    output logic [2**A_WIDTH-1:0]    busy
);
    localparam int DEPTH = 2**A_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int k = 1; k < DEPTH; k++) begin
                // A new issue beats a same-cycle write-back: the newer producer is still outstanding.
                if (iss_en && iss_addr == A_WIDTH'(k)) begin
                    busy[k] <= 1'b1;
                end else if ((wr_en[0] && wr_addr[0 +: A_WIDTH] == A_WIDTH'(k)) ||
                             (wr_en[1] && wr_addr[A_WIDTH +: A_WIDTH] == A_WIDTH'(k))) begin
                    busy[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hard-wired zero register, optional write-through and RAW scoreboard.
// Latency: reads and busy flags combinational; writes commit on the rising clk edge.
// Backpressure: none; all ports accepted every cycle.
//   clk, rst_n : clock and async active-low reset (clears contents and busy bits)
//   bus        : regfile_mp_if slave (read/write/issue ports, dbg_data tap)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int A_WIDTH       = 5,
    parameter int D_WIDTH       = 32,
    parameter int NR            = 2,
    parameter int NW            = 1,
    parameter int WRITE_THROUGH = 1,
    parameter int DBG_IDX       = REG_A0
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**A_WIDTH;

    // Write ports widened to MAX_NW so the bypass and scoreboard logic is port-count agnostic.
    logic [MAX_NW-1:0]          we;
    logic [A_WIDTH-1:0]         wa [MAX_NW];
    logic [D_WIDTH-1:0]         wd [MAX_NW];
    logic [MAX_NW*A_WIDTH-1:0]  wa_packed;

    for (genvar j = 0; j < MAX_NW; j++) begin : g_wp
        if (j < NW) begin : g_used
            assign we[j] = bus.wr_en[j];
            assign wa[j] = bus.wr_addr[j*A_WIDTH +: A_WIDTH];
            assign wd[j] = bus.wr_data[j*D_WIDTH +: D_WIDTH];
        end else begin : g_tied
            assign we[j] = 1'b0;
            assign wa[j] = '0;
            assign wd[j] = '0;
        end
        assign wa_packed[j*A_WIDTH +: A_WIDTH] = wa[j];
    end

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   busy;

    // Later ports overwrite earlier ones on a collision; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < MAX_NW; j++) begin
                if (we[j] && wa[j] != A_WIDTH'(REG_ZERO)) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    regfile_scoreboard #(
        .A_WIDTH (A_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (we),
        .wr_addr  (wa_packed),
        .busy     (busy)
    );

    // Lookup slots: one per read port plus a final slot for the debug tap.
    logic [A_WIDTH-1:0] lk_addr [NR+1];
    logic [D_WIDTH-1:0] lk_data [NR+1];
    logic               lk_busy [NR+1];
    logic [MAX_NW-1:0]  hit;
    byp_t               sel;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            lk_addr[i] = bus.rd_addr[i*A_WIDTH +: A_WIDTH];
        end
        lk_addr[NR] = A_WIDTH'(DBG_IDX);
    end

    always_comb begin
        hit = '0;
        sel = '0;
        for (int i = 0; i <= NR; i++) begin
            for (int j = 0; j < MAX_NW; j++) begin
                hit[j] = we[j] && (wa[j] == lk_addr[i]);
            end
            sel        = bypass_sel(hit);
            lk_data[i] = mem[lk_addr[i]];
            lk_busy[i] = busy[lk_addr[i]];
            // Forwarded data is already the producer's result, so the hazard is hidden too.
            if (WRITE_THROUGH != 0 && sel.hit) begin
                lk_data[i] = wd[sel.port];
                lk_busy[i] = 1'b0;
            end
            // x0 and the in-reset state read as zero, whatever is on the write ports.
            if (lk_addr[i] == A_WIDTH'(REG_ZERO) || !rst_n) begin
                lk_data[i] = '0;
                lk_busy[i] = 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            bus.rd_data[i*D_WIDTH +: D_WIDTH] = lk_data[i];
            bus.rd_busy[i]                    = lk_busy[i];
        end
        bus.dbg_data = lk_data[NR];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: dut_a (NW=2, write-through) and dut_b (NW=1, no write-through).
// Stimulus pushes expected read results; a negedge monitor pops and compares them.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk;
    logic rst_n;

    regfile_mp_if #(.A_WIDTH(5), .D_WIDTH(32), .NR(2), .NW(2)) bus_a ();
    regfile_mp_if #(.A_WIDTH(5), .D_WIDTH(32), .NR(2), .NW(1)) bus_b ();

    regfile_mp #(
        .A_WIDTH(5), .D_WIDTH(32), .NR(2), .NW(2), .WRITE_THROUGH(1), .DBG_IDX(10)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    regfile_mp #(
        .A_WIDTH(5), .D_WIDTH(32), .NR(2), .NW(1), .WRITE_THROUGH(0), .DBG_IDX(10)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        int          port;   // -1 selects dbg_data
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    function automatic logic [32:0] probe(input int dut, input int port);
        if (dut == 0) begin
            if (port < 0) return {1'b0, bus_a.dbg_data};
            return {bus_a.rd_busy[port], bus_a.rd_data[port*32 +: 32]};
        end
        if (port < 0) return {1'b0, bus_b.dbg_data};
        return {bus_b.rd_busy[port], bus_b.rd_data[port*32 +: 32]};
    endfunction

    // Monitor: outputs are combinational, so every pending expectation is due at the next negedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] got;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = probe(e.dut, e.port);
            n_tests++;
            if (got !== {e.busy, e.data}) begin
                n_fail++;
                $display("FAIL %s: got data=%h busy=%b, want data=%h busy=%b",
                         e.name, got[31:0], got[32], e.data, e.busy);
            end
        end
    end

    // Immediate check, used where no clock edge may be involved.
    task automatic check_now(input int dut, input int port, input logic [31:0] data,
                             input logic busy, input string name);
        logic [32:0] got;
        got = probe(dut, port);
        n_tests++;
        if (got !== {busy, data}) begin
            n_fail++;
            $display("FAIL %s (immediate): got data=%h busy=%b, want data=%h busy=%b",
                     name, got[31:0], got[32], data, busy);
        end
    endtask

    // Watchdog: the sequence must finish within a bounded time.
    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: bench did not complete, %0d tests run", n_tests);
            $finish;
        end
    end

    task automatic expect_rd(input int dut, input int port, input logic [31:0] data,
                             input logic busy, input string name);
        exp_t e;
        e.dut = dut; e.port = port; e.data = data; e.busy = busy; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.iss_en = 1'b0; bus_a.iss_addr = '0;
        bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.iss_en = 1'b0; bus_b.iss_addr = '0;
    endtask

    task automatic wr_a(input int p, input reg_addr_t a, input reg_data_t d);
        bus_a.wr_en[p]            = 1'b1;
        bus_a.wr_addr[p*5 +: 5]   = a;
        bus_a.wr_data[p*32 +: 32] = d;
    endtask

    task automatic wr_b(input reg_addr_t a, input reg_data_t d);
        bus_b.wr_en[0]   = 1'b1;
        bus_b.wr_addr    = a;
        bus_b.wr_data    = d;
    endtask

    task automatic iss_both(input reg_addr_t a);
        bus_a.iss_en = 1'b1; bus_a.iss_addr = a;
        bus_b.iss_en = 1'b1; bus_b.iss_addr = a;
    endtask

    task automatic rd_both(input int p, input reg_addr_t a);
        bus_a.rd_addr[p*5 +: 5] = a;
        bus_b.rd_addr[p*5 +: 5] = a;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.rd_addr = '0;
        bus_b.rd_addr = '0;
        idle();

        // Reset: a write attempted while in reset is neither visible nor kept.
        wr_a(0, 5'd5, 32'h0000_0099);
        rd_both(0, 5'd5);
        rd_both(1, 5'd10);
        step();
        step();
        check_now(0, 0, 32'h0, 1'b0, "rst_now_a_x5");
        check_now(0, -1, 32'h0, 1'b0, "rst_now_a_dbg");
        expect_rd(0, 0, 32'h0, 1'b0, "rst_a_x5");
        expect_rd(0, 1, 32'h0, 1'b0, "rst_a_x10");
        expect_rd(0, -1, 32'h0, 1'b0, "rst_a_dbg");
        expect_rd(1, 0, 32'h0, 1'b0, "rst_b_x5");
        expect_rd(1, -1, 32'h0, 1'b0, "rst_b_dbg");
        step();
        rst_n = 1'b1;
        idle();
        expect_rd(0, 0, 32'h0, 1'b0, "rst_write_lost");

        // Basic write x10: same-cycle bypass on A only.
        step();
        wr_a(0, 5'd10, 32'hDEAD_BEEF);
        wr_b(5'd10, 32'hDEAD_BEEF);
        expect_rd(0, 1, 32'hDEAD_BEEF, 1'b0, "wt1_same_cycle");
        expect_rd(0, -1, 32'hDEAD_BEEF, 1'b0, "wt1_dbg_same_cycle");
        expect_rd(1, 1, 32'h0, 1'b0, "wt0_same_cycle");
        expect_rd(1, -1, 32'h0, 1'b0, "wt0_dbg_same_cycle");
        step();
        idle();
        expect_rd(0, 1, 32'hDEAD_BEEF, 1'b0, "wt1_next_cycle");
        expect_rd(1, 1, 32'hDEAD_BEEF, 1'b0, "wt0_next_cycle");
        expect_rd(1, -1, 32'hDEAD_BEEF, 1'b0, "wt0_dbg_next_cycle");

        // Zero register: write and issue to x0 have no effect.
        step();
        wr_a(0, 5'd0, 32'h1234_5678);
        wr_b(5'd0, 32'h1234_5678);
        iss_both(5'd0);
        rd_both(0, 5'd0);
        expect_rd(0, 0, 32'h0, 1'b0, "x0_a_same_cycle");
        expect_rd(1, 0, 32'h0, 1'b0, "x0_b_same_cycle");
        step();
        idle();
        expect_rd(0, 0, 32'h0, 1'b0, "x0_a_after");
        expect_rd(1, 0, 32'h0, 1'b0, "x0_b_after");

        // Dual-write collision on x7: port 1 wins, both bypass and commit.
        step();
        wr_a(0, 5'd7, 32'h1);
        wr_a(1, 5'd7, 32'h2);
        rd_both(0, 5'd7);
        expect_rd(0, 0, 32'h2, 1'b0, "collide_bypass");
        step();
        idle();
        expect_rd(0, 0, 32'h2, 1'b0, "collide_commit");
        expect_rd(1, 0, 32'h0, 1'b0, "collide_b_untouched");

        // Scoreboard on x3.
        step();
        iss_both(5'd3);
        rd_both(0, 5'd3);
        expect_rd(0, 0, 32'h0, 1'b0, "issue_not_yet_busy");
        step();
        idle();
        expect_rd(0, 0, 32'h0, 1'b1, "issue_a_busy");
        expect_rd(1, 0, 32'h0, 1'b1, "issue_b_busy");
        step();
        wr_a(0, 5'd3, 32'h55);
        wr_b(5'd3, 32'h55);
        expect_rd(0, 0, 32'h55, 1'b0, "wb_a_forward_masked");
        expect_rd(1, 0, 32'h0, 1'b1, "wb_b_no_mask");
        step();
        idle();
        expect_rd(0, 0, 32'h55, 1'b0, "wb_a_cleared");
        expect_rd(1, 0, 32'h55, 1'b0, "wb_b_cleared");
        step();
        iss_both(5'd3);
        wr_a(0, 5'd3, 32'h66);
        wr_b(5'd3, 32'h66);
        expect_rd(0, 0, 32'h66, 1'b0, "iss_wr_a_same_cycle");
        expect_rd(1, 0, 32'h55, 1'b0, "iss_wr_b_same_cycle");
        step();
        idle();
        expect_rd(0, 0, 32'h66, 1'b1, "iss_wr_a_busy_kept");
        expect_rd(1, 0, 32'h66, 1'b1, "iss_wr_b_busy_kept");
        expect_rd(0, 1, 32'hDEAD_BEEF, 1'b0, "x10_undisturbed");

        // Async reset between edges with x4 holding data and busy.
        step();
        wr_a(0, 5'd4, 32'hAA);
        wr_b(5'd4, 32'hAA);
        iss_both(5'd4);
        step();
        idle();
        rd_both(0, 5'd4);
        expect_rd(0, 0, 32'hAA, 1'b1, "pre_rst_a_x4");
        expect_rd(1, 0, 32'hAA, 1'b1, "pre_rst_b_x4");
        step();
        rst_n = 1'b0;
        #1;
        check_now(0, 0, 32'h0, 1'b0, "async_rst_now_a_x4");
        check_now(1, 0, 32'h0, 1'b0, "async_rst_now_b_x4");
        expect_rd(0, 0, 32'h0, 1'b0, "async_rst_a_x4");
        expect_rd(1, 0, 32'h0, 1'b0, "async_rst_b_x4");
        expect_rd(0, 1, 32'h0, 1'b0, "async_rst_a_x10");
        expect_rd(0, -1, 32'h0, 1'b0, "async_rst_a_dbg");
        step();
        rst_n = 1'b1;
        step();
        expect_rd(0, 0, 32'h0, 1'b0, "post_rst_a_x4");
        expect_rd(1, 0, 32'h0, 1'b0, "post_rst_b_x4");
        expect_rd(1, -1, 32'h0, 1'b0, "post_rst_b_dbg");

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
